// File: rtl/stream_switch_pkg.sv
// Shared definitions for the stream-switch splitter register slave:
// register offsets, ID default, AXI response codes and FSM state types.
package stream_switch_pkg;

    localparam logic [11:0] OFF_ID       = 12'h000;
    localparam logic [11:0] OFF_CTRL     = 12'h004;
    localparam logic [11:0] OFF_STATUS   = 12'h008;
    localparam logic [11:0] OFF_CNT_CLR  = 12'h00C;
    localparam logic [11:0] OFF_CNT_BASE = 12'h010;
    localparam logic [11:0] OFF_SCRATCH  = 12'h020;

    localparam logic [31:0] ID_DEFAULT    = 32'h5350_4C54;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

endpackage

// File: rtl/stream_switch_stat_counter.sv
// 32-bit packet counter; a clear wins over an increment, but a coincident
// increment still counts, leaving the counter at 1.
module stream_switch_stat_counter
    import stream_switch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? 32'd1 : 32'd0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/stream_switch_splitter_csr.sv
// AXI-Lite register slave for the splitter: shadowed CTRL applied at packet boundaries,
// ID/STATUS/SCRATCH, and per-output packet counters when STREAM_SWITCH_SPLITTER_STATS_EN is defined.
module stream_switch_splitter_csr
    import stream_switch_pkg::*;
#(
    parameter int          NUM_PORTS = 2,
    parameter logic [31:0] ID_VALUE  = ID_DEFAULT,
    localparam int         DW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_axil_awvalid,
    output logic                 s_axil_awready,
    input  logic [31:0]          s_axil_awaddr,
    input  logic                 s_axil_wvalid,
    output logic                 s_axil_wready,
    input  logic [31:0]          s_axil_wdata,
    output logic                 s_axil_bvalid,
    input  logic                 s_axil_bready,
    output logic [1:0]           s_axil_bresp,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,
    input  logic [31:0]          s_axil_araddr,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready,
    output logic [31:0]          s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    input  logic                 dp_idle,
    input  logic [NUM_PORTS-1:0] pkt_done,
    output logic                 splitter_enable,
    output logic [DW-1:0]        splitter_dest
);

    localparam logic [DW:0] DEST_LIMIT = (DW + 1)'(NUM_PORTS);

    wstate_t     wstate;
    rstate_t     rstate;
    logic        aw_hs, w_hs, wr_fire;
    logic [11:2] aw_addr_q;
    logic [31:0] w_data_q;
    logic [11:0] wr_off, rd_off;
    logic [31:0] wr_data;
    logic        wr_is_ctrl, wr_is_clr, wr_is_scratch;
    logic [1:0]  wr_resp;
    logic [DW:0] ctrl;
    logic        pending;
    logic [31:0] scratch;
    logic [31:0] rd_data_c;
    logic [1:0]  rd_resp_c;
    logic        unused_bits;

    function automatic logic [DW-1:0] apply_dest(input logic [DW:0] c);
        if ({1'b0, c[DW:1]} >= DEST_LIMIT) return '0;
        return c[DW:1];
    endfunction

    assign aw_hs   = s_axil_awvalid & s_axil_awready;
    assign w_hs    = s_axil_wvalid & s_axil_wready;
    assign wr_fire = ((wstate == W_IDLE) & aw_hs & w_hs) |
                     ((wstate == W_HAVE_A) & w_hs) |
                     ((wstate == W_HAVE_D) & aw_hs);

    // Whichever half arrived earlier comes from the holding register, the other is live.
    assign wr_off  = (wstate == W_HAVE_A) ? {aw_addr_q, 2'b00} : {s_axil_awaddr[11:2], 2'b00};
    assign wr_data = (wstate == W_HAVE_D) ? w_data_q : s_axil_wdata;

    assign wr_is_ctrl    = (wr_off == OFF_CTRL);
    assign wr_is_clr     = (wr_off == OFF_CNT_CLR);
    assign wr_is_scratch = (wr_off == OFF_SCRATCH);
    assign wr_resp       = (wr_is_ctrl | wr_is_clr | wr_is_scratch) ? RESP_OKAY : RESP_SLVERR;
    assign rd_off        = {s_axil_araddr[11:2], 2'b00};

`ifdef STREAM_SWITCH_SPLITTER_STATS_EN
    logic [31:0]          cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] clr_vec;

    assign clr_vec = {NUM_PORTS{wr_fire & wr_is_clr}} & wr_data[NUM_PORTS-1:0];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
        stream_switch_stat_counter u_cnt (
            .clk   (aclk),
            .rst   (areset),
            .inc   (pkt_done[i]),
            .clr   (clr_vec[i]),
            .count (cnt[i])
        );
    end

    assign unused_bits = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                           s_axil_araddr[31:12], s_axil_araddr[1:0]};
`else
    assign unused_bits = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                           s_axil_araddr[31:12], s_axil_araddr[1:0], pkt_done};
`endif

    always_ff @(posedge aclk) begin
        if (aw_hs) aw_addr_q <= s_axil_awaddr[11:2];
        if (w_hs)  w_data_q  <= s_axil_wdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate         <= W_IDLE;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wstate         <= W_RESP;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                        s_axil_bvalid  <= 1'b1;
                        s_axil_bresp   <= wr_resp;
                    end else if (aw_hs) begin
                        wstate         <= W_HAVE_A;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b1;
                    end else if (w_hs) begin
                        wstate         <= W_HAVE_D;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b0;
                    end else begin
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                    end
                end
                W_HAVE_A, W_HAVE_D: begin
                    if (wr_fire) begin
                        wstate         <= W_RESP;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                        s_axil_bvalid  <= 1'b1;
                        s_axil_bresp   <= wr_resp;
                    end
                end
                default: begin
                    if (s_axil_bready) begin
                        wstate         <= W_IDLE;
                        s_axil_bvalid  <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // A CTRL write racing an apply keeps pending so the newer shadow value still lands.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl            <= '0;
            pending         <= 1'b0;
            scratch         <= '0;
            splitter_enable <= 1'b0;
            splitter_dest   <= '0;
        end else begin
            if (pending && dp_idle) begin
                splitter_enable <= ctrl[0];
                splitter_dest   <= apply_dest(ctrl);
            end
            if (wr_fire && wr_is_ctrl) begin
                ctrl    <= wr_data[DW:0];
                pending <= 1'b1;
            end else if (pending && dp_idle) begin
                pending <= 1'b0;
            end
            if (wr_fire && wr_is_scratch) scratch <= wr_data;
        end
    end

    always_comb begin
        rd_data_c = UNMAPPED_DATA;
        rd_resp_c = RESP_SLVERR;
        case (rd_off)
            OFF_ID:      begin rd_data_c = ID_VALUE;          rd_resp_c = RESP_OKAY; end
            OFF_CTRL:    begin rd_data_c = 32'(ctrl);         rd_resp_c = RESP_OKAY; end
            OFF_STATUS:  begin rd_data_c = {31'b0, pending};  rd_resp_c = RESP_OKAY; end
            OFF_CNT_CLR: begin rd_data_c = '0;                rd_resp_c = RESP_OKAY; end
            OFF_SCRATCH: begin rd_data_c = scratch;           rd_resp_c = RESP_OKAY; end
            default: ;
        endcase
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_off == OFF_CNT_BASE + 12'(4 * i)) begin
`ifdef STREAM_SWITCH_SPLITTER_STATS_EN
                rd_data_c = cnt[i];
`else
                rd_data_c = '0;
`endif
                rd_resp_c = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate         <= R_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axil_arvalid && s_axil_arready) begin
                        rstate         <= R_RESP;
                        s_axil_arready <= 1'b0;
                        s_axil_rvalid  <= 1'b1;
                        s_axil_rdata   <= rd_data_c;
                        s_axil_rresp   <= rd_resp_c;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                default: begin
                    if (s_axil_rready) begin
                        rstate         <= R_IDLE;
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_switch_splitter_csr.sv
// Scoreboard bench for stream_switch_splitter_csr (NUM_PORTS=3); expectations follow
// STREAM_SWITCH_SPLITTER_STATS_EN when it is defined for the build.
module tb_stream_switch_splitter_csr;

    localparam int NP = 3;
    localparam int DW = 2;
`ifdef STREAM_SWITCH_SPLITTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [31:0] ID_EXP = 32'h5350_4C54;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic          aclk = 1'b0;
    logic          areset;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [1:0]    bresp, rresp;
    logic          dp_idle;
    logic [NP-1:0] pkt_done;
    logic          splitter_enable;
    logic [DW-1:0] splitter_dest;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];

    always #2 aclk = ~aclk;

    stream_switch_splitter_csr #(.NUM_PORTS(NP)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_axil_awvalid  (awvalid),
        .s_axil_awready  (awready),
        .s_axil_awaddr   (awaddr),
        .s_axil_wvalid   (wvalid),
        .s_axil_wready   (wready),
        .s_axil_wdata    (wdata),
        .s_axil_bvalid   (bvalid),
        .s_axil_bready   (bready),
        .s_axil_bresp    (bresp),
        .s_axil_arvalid  (arvalid),
        .s_axil_arready  (arready),
        .s_axil_araddr   (araddr),
        .s_axil_rvalid   (rvalid),
        .s_axil_rready   (rready),
        .s_axil_rdata    (rdata),
        .s_axil_rresp    (rresp),
        .dp_idle         (dp_idle),
        .pkt_done        (pkt_done),
        .splitter_enable (splitter_enable),
        .splitter_dest   (splitter_dest)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input int lead, input logic [NP-1:0] pulse);
        int n;
        if (lead > 0) begin
            wvalid = 1'b1; wdata = data; n = 0;
            while (!wready && n < 50) begin tick; n++; end
            if (n >= 50) check("w_timeout", 32'd0, 32'd1);
            tick;
            wvalid = 1'b0;
            repeat (lead) tick;
            awvalid = 1'b1; awaddr = addr; n = 0;
            while (!awready && n < 50) begin tick; n++; end
            if (n >= 50) check("aw_timeout", 32'd0, 32'd1);
        end else begin
            awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; n = 0;
            while (!(awready && wready) && n < 50) begin tick; n++; end
            if (n >= 50) check("aww_timeout", 32'd0, 32'd1);
        end
        pkt_done = pulse;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; pkt_done = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] exp,
                      input int lead = 0, input logic [NP-1:0] pulse = '0, input int hold = 0);
        int n;
        logic [1:0] e, r0;
        bq.push_back(exp);
        send_aw_w(addr, data, lead, pulse);
        check("bvalid_lat", 32'(bvalid), 32'd1);
        n = 0;
        while (!bvalid && n < 20) begin tick; n++; end
        e = bq.pop_front();
        check($sformatf("bresp@%h", addr), 32'(bresp), 32'(e));
        r0 = bresp;
        for (int i = 0; i < hold; i++) begin
            tick;
            check("b_hold", 32'({bvalid, bresp, awready, wready}), 32'({1'b1, r0, 2'b00}));
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("b_done", 32'(bvalid), 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                      input int hold = 0);
        int n;
        rexp_t e;
        logic [31:0] d0;
        rq.push_back('{exp_data, exp_resp});
        arvalid = 1'b1; araddr = addr; n = 0;
        while (!arready && n < 50) begin tick; n++; end
        if (n >= 50) check("ar_timeout", 32'd0, 32'd1);
        tick;
        arvalid = 1'b0;
        check("rvalid_lat", 32'(rvalid), 32'd1);
        n = 0;
        while (!rvalid && n < 20) begin tick; n++; end
        e = rq.pop_front();
        check($sformatf("rdata@%h", addr), rdata, e.data);
        check($sformatf("rresp@%h", addr), 32'(rresp), 32'(e.resp));
        d0 = rdata;
        for (int i = 0; i < hold; i++) begin
            tick;
            check("r_hold_ctl", 32'({rvalid, arready}), 32'b10);
            check("r_hold_data", rdata, d0);
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; wdata = '0; araddr = '0;
        dp_idle = 1'b0; pkt_done = '0;
        repeat (3) tick;
        check("rst_ctl", 32'({awready, wready, arready, bvalid, rvalid, splitter_enable, splitter_dest}), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        areset = 1'b0;
        tick;

        // ID read
        rd(32'h000, ID_EXP, OKAY);

        // CTRL shadow held until dp_idle, W ahead of AW
        wr(32'h004, 32'h3, OKAY, 3);
        check("hold_en", 32'(splitter_enable), 32'd0);
        check("hold_dest", 32'(splitter_dest), 32'd0);
        rd(32'h008, 32'd1, OKAY);
        rd(32'h004, 32'h3, OKAY);
        dp_idle = 1'b1;
        tick;
        check("apply_en", 32'(splitter_enable), 32'd1);
        check("apply_dest", 32'(splitter_dest), 32'd1);
        rd(32'h008, 32'd0, OKAY);

        // dest out of range is stored but applied as 0; dp_idle already high
        wr(32'h004, 32'h7, OKAY);
        check("oor_en", 32'(splitter_enable), 32'd1);
        check("oor_dest", 32'(splitter_dest), 32'd0);
        rd(32'h004, 32'h7, OKAY);
        wr(32'h004, 32'h5, OKAY);
        check("dest2", 32'(splitter_dest), 32'd2);

        // error responses
        wr(32'h020, 32'hA5A5_1234, OKAY);
        wr(32'h040, 32'hFFFF_FFFF, SLVERR);
        rd(32'h044, 32'hDEAD_BEEF, SLVERR);
        rd(32'h020, 32'hA5A5_1234, OKAY);
        wr(32'h000, 32'h0, SLVERR);
        wr(32'h008, 32'h1, SLVERR);
        rd(32'h000, ID_EXP, OKAY);

        // counters
        for (int i = 0; i < 5; i++) begin
            pkt_done = 3'b010;
            tick;
            pkt_done = '0;
            tick;
        end
        rd(32'h014, STATS ? 32'd5 : 32'd0, OKAY);
        rd(32'h010, 32'd0, OKAY);
        wr(32'h014, 32'h0, SLVERR);
        wr(32'h00C, 32'h2, OKAY, 0, 3'b010);
        rd(32'h014, STATS ? 32'd1 : 32'd0, OKAY);

        // backpressure on B and R
        wr(32'h020, 32'h0BAD_F00D, OKAY, 0, '0, 10);
        rd(32'h020, 32'h0BAD_F00D, OKAY, 10);

        // reset while the write response is pending
        send_aw_w(32'h020, 32'h1111_2222, 0, '0);
        check("wresp_pending", 32'(bvalid), 32'd1);
        tick;
        tick;
        areset = 1'b1;
        tick;
        check("rst_wresp", 32'({bvalid, awready, wready, arready, rvalid, splitter_enable, splitter_dest}), 32'd0);
        areset = 1'b0;
        tick;
        rd(32'h020, 32'd0, OKAY);
        rd(32'h004, 32'd0, OKAY);
        rd(32'h014, 32'd0, OKAY);
        wr(32'h020, 32'hCAFE_0001, OKAY);
        rd(32'h020, 32'hCAFE_0001, OKAY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
